// File: rtl/axi_lite_write_arbiter.sv
// Round-robin arbiter that funnels single-beat writes from NUM_REQ local
// requesters onto one AXI4-Lite write channel, one transaction at a time.
module axi_lite_write_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int GRANT_WIDTH = 3
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]         req_data,
  input  logic [NUM_REQ*4-1:0]          req_strb,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [1:0]                    rsp_resp,
  output logic                          busy,
  output logic [GRANT_WIDTH-1:0]        grant_id,
  output logic [7:0]                    err_count,
  output logic [ADDR_WIDTH-1:0]         m_axi_lite_awaddr,
  output logic [2:0]                    m_axi_lite_awprot,
  output logic                          m_axi_lite_awvalid,
  input  logic                          m_axi_lite_awready,
  output logic [31:0]                   m_axi_lite_wdata,
  output logic [3:0]                    m_axi_lite_wstrb,
  output logic                          m_axi_lite_wvalid,
  input  logic                          m_axi_lite_wready,
  input  logic [1:0]                    m_axi_lite_bresp,
  input  logic                          m_axi_lite_bvalid,
  output logic                          m_axi_lite_bready
);

  localparam int SLOTS = 1 << GRANT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [GRANT_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [GRANT_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ADDR_WIDTH-1:0]    awaddr_q, awaddr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0]               wstrb_q, wstrb_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0]               rsp_resp_q, rsp_resp_d;
  logic [7:0]               err_count_q, err_count_d;

  logic [SLOTS-1:0]         req_ext_s;
  logic [GRANT_WIDTH-1:0]   sel_s;
  logic [GRANT_WIDTH-1:0]   cand_s;
  logic                     sel_found_s;
  int                       cand_i;
  logic                     accept_s;
  logic [ADDR_WIDTH-1:0]    addr_sel_s;
  logic [31:0]              data_sel_s;
  logic [3:0]               strb_sel_s;
  logic [NUM_REQ-1:0]       req_ready_s;
  logic [NUM_REQ-1:0]       grant_hot_s;
  logic                     aw_done_s;
  logic                     w_done_s;

  assign req_ext_s = SLOTS'(req_valid);

  // Round-robin pick: first valid requester above the last one served.
  always_comb begin
    sel_s       = '0;
    sel_found_s = 1'b0;
    cand_i      = 0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = (int'(last_grant_q) + k >= NUM_REQ) ? (int'(last_grant_q) + k - NUM_REQ)
                                                   : (int'(last_grant_q) + k);
      cand_s = cand_i[GRANT_WIDTH-1:0];
      if (!sel_found_s && req_ext_s[cand_s]) begin
        sel_found_s = 1'b1;
        sel_s       = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign accept_s = (state_q == ST_IDLE) && sel_found_s && !s_axi_areset;

  // Payload mux and one-hot decodes for the selected and granted requester.
  always_comb begin
    addr_sel_s  = '0;
    data_sel_s  = 32'h0000_0000;
    strb_sel_s  = 4'h0;
    req_ready_s = '0;
    grant_hot_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_s == GRANT_WIDTH'(i)) begin
        addr_sel_s     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_sel_s     = req_data[i*32 +: 32];
        strb_sel_s     = req_strb[i*4 +: 4];
        req_ready_s[i] = accept_s;
      end else begin
        req_ready_s[i] = 1'b0;
      end
      if (grant_id_q == GRANT_WIDTH'(i)) begin
        grant_hot_s[i] = 1'b1;
      end else begin
        grant_hot_s[i] = 1'b0;
      end
    end
  end

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done_s = !awvalid_q || m_axi_lite_awready;
  assign w_done_s  = !wvalid_q || m_axi_lite_wready;

  // Next-state and register-update logic for the transfer FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    rsp_valid_d  = '0;
    rsp_resp_d   = rsp_resp_q;
    err_count_d  = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_XFER;
          awaddr_d     = addr_sel_s;
          wdata_d      = data_sel_s;
          wstrb_d      = strb_sel_s;
          grant_id_d   = sel_s;
          last_grant_d = sel_s;
          awvalid_d    = 1'b1;
          wvalid_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (awvalid_q && m_axi_lite_awready) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q && m_axi_lite_wready) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (aw_done_s && w_done_s) begin
          state_d  = ST_RESP;
          bready_d = 1'b1;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_RESP: begin
        if (bready_q && m_axi_lite_bvalid) begin
          state_d     = ST_IDLE;
          bready_d    = 1'b0;
          rsp_valid_d = grant_hot_s;
          rsp_resp_d  = m_axi_lite_bresp;
          if ((m_axi_lite_bresp != 2'b00) && (err_count_q != 8'd255)) begin
            err_count_d = err_count_q + 8'd1;
          end else begin
            err_count_d = err_count_q;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any write in flight.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_WIDTH'(NUM_REQ - 1);
      grant_id_q   <= '0;
      awaddr_q     <= '0;
      wdata_q      <= 32'h0000_0000;
      wstrb_q      <= 4'h0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_resp_q   <= 2'b00;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_resp_q   <= rsp_resp_d;
      err_count_q  <= err_count_d;
    end
  end

  assign req_ready          = req_ready_s;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_resp           = rsp_resp_q;
  assign busy               = (state_q != ST_IDLE);
  assign grant_id           = grant_id_q;
  assign err_count          = err_count_q;
  assign m_axi_lite_awaddr  = awaddr_q;
  assign m_axi_lite_awprot  = 3'b000;
  assign m_axi_lite_awvalid = awvalid_q;
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_wstrb   = wstrb_q;
  assign m_axi_lite_wvalid  = wvalid_q;
  assign m_axi_lite_bready  = bready_q;

endmodule
